// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_ARMED = 2'd2,
    S_HIT   = 2'd3
  } state_t;

  localparam logic MODE_RUN = 1'b0;
  localparam logic MODE_PAT = 1'b1;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int clog2_p1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'd1 << r) < 64'(n) + 64'd1) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_shift_window.sv
// Sample window for the sequence detector: RUN_LEN-bit shift register
// (newest bit at LSB) plus a saturating count of samples taken.
module seq_shift_window
  import seq_det_pkg::*;
#(
  parameter int RUN_LEN = 4,
  localparam int FW = clog2_p1(RUN_LEN)
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic               clr,
  input  logic               en,
  input  logic               w,
  output logic [RUN_LEN-1:0] window,
  output logic [FW-1:0]      fill
);

  localparam logic [FW-1:0] FULL = FW'(RUN_LEN);

  // Shift on each enabled sample; reset and soft clear empty the window.
  always_ff @(posedge CLOCK_50) begin
    if (Reset || clr) begin
      window <= '0;
      fill   <= '0;
    end else if (en) begin
      window <= {window[RUN_LEN-2:0], w};
      if (fill != FULL) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial run / pattern detector with overlap.
// Optional detection counter enabled by defining SEQ_DET_COUNT_EN.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 RUN_LEN = 4,
  parameter logic [RUN_LEN-1:0] PATTERN = 4'b1011,
`ifdef SEQ_DET_COUNT_EN
  parameter int                 CNT_W   = 8,
`endif
  localparam int                RL_W    = clog2_p1(RUN_LEN)
) (
  input  logic            CLOCK_50,
  input  logic            Reset,
  input  logic            en,
  input  logic            w,
  input  logic            mode,
  output logic            z,
  output logic            z_val,
  output logic [RL_W-1:0] run_len,
  output logic [1:0]      state
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0] det_count
`endif
);

  localparam logic [RL_W-1:0] FULL = RL_W'(RUN_LEN);

  logic               mode_q, last_bit, mode_chg;
  logic [RUN_LEN-1:0] window, win_n;
  logic [RL_W-1:0]    fill, fill_n, rl_n;
  logic               detect, z_n;
  state_t             st, st_n;

  // A mode flip is a soft clear; it also blocks the sample on that edge.
  assign mode_chg = (mode != mode_q);
  assign state    = st;

  seq_shift_window #(.RUN_LEN(RUN_LEN)) u_win (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .clr      (mode_chg),
    .en       (en),
    .w        (w),
    .window   (window),
    .fill     (fill)
  );

  // Post-shift view of the sample, detect condition and FSM next state.
  always_comb begin
    win_n  = RUN_LEN'({window, w});
    fill_n = (fill == FULL) ? fill : fill + 1'b1;
    if (w != last_bit || fill == '0) rl_n = RL_W'(1);
    else if (run_len == FULL)        rl_n = run_len;
    else                             rl_n = run_len + 1'b1;
    detect = (mode_q == MODE_PAT) ? (fill_n == FULL && win_n == PATTERN)
                                  : (rl_n == FULL);
    st_n = st;
    z_n  = z;
    if (mode_chg) begin
      st_n = S_IDLE;
      z_n  = 1'b0;
    end else if (en) begin
      z_n = detect;
      if (fill_n != FULL) st_n = S_FILL;
      else if (detect)    st_n = S_HIT;
      else                st_n = S_ARMED;
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) st <= S_IDLE;
    else       st <= st_n;
  end

  // Run counter, flag and run value. Reset captures the current mode so a
  // mode held through reset does not cost a soft-clear edge afterwards.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      mode_q   <= mode;
      last_bit <= 1'b0;
      run_len  <= '0;
      z        <= 1'b0;
      z_val    <= 1'b0;
    end else begin
      mode_q <= mode;
      if (mode_chg) begin
        run_len <= '0;
      end else if (en) begin
        run_len  <= rl_n;
        last_bit <= w;
      end
      z <= z_n;
      if (z_n && !z) z_val <= (mode_q == MODE_RUN) ? w : 1'b0;
    end
  end

`ifdef SEQ_DET_COUNT_EN
  // Saturating count of z rising edges; only a hard reset clears it.
  always_ff @(posedge CLOCK_50) begin
    if (Reset)                            det_count <= '0;
    else if (z_n && !z && det_count != '1) det_count <= det_count + 1'b1;
  end
`endif

endmodule
